// File: rtl/prime_pkg.sv
// Shared definitions for the sequential prime checker.
// Holds the controller state encoding, the trial-divisor constants and a helper that sizes the
// d*d product so the square never overflows.
package prime_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StTest,
    StMod,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned ProdWidth    = 2 * DefaultWidth;

  // First odd divisor tried and the stride between candidates
  localparam int unsigned DivStart = 3;
  localparam int unsigned DivStep  = 2;

  // d*d needs twice the operand width to be exact
  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/prime_seq_checker_if.sv
// Operand / result handshake bundle for prime_seq_checker.
//   in_valid, in_data, in_ready : operand channel (source -> checker)
//   out_valid, out_ready        : result channel (checker -> consumer)
//   isprime, factor             : result payload, meaningful while out_valid is high
// master: operand source plus result consumer. slave: the checker.
interface prime_seq_checker_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             isprime;
  logic [WIDTH-1:0] factor;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  isprime,
    input  factor
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output isprime,
    output factor
  );
endinterface

// File: rtl/prime_mod_unit.sv
// Restoring shift-subtract remainder unit: rem_o = n_i mod d_i, one quotient bit per cycle.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   start_i       : load n_i/d_i; the first bit is processed on the load edge
//   n_i, d_i      : dividend and divisor (d_i must be non-zero)
//   rem_o         : remainder, final once done_o is high, held until the next start
//   done_o        : single-cycle pulse, high in the WIDTH-th cycle after start
module prime_mod_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] rem,
                                                input logic             nbit,
                                                input logic [WIDTH-1:0] d);
    logic [WIDTH:0] trial;
    trial = {rem, nbit};
    if (trial >= {1'b0, d}) begin
      trial = trial - {1'b0, d};
    end
    return trial[WIDTH-1:0];
  endfunction

  always_comb begin
    rem_d   = rem_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start_i) begin
      // Processing the MSB on the load edge lets the result land inside the WIDTH-cycle window
      rem_d   = mod_step('0, n_i[WIDTH-1], d_i);
      shreg_d = n_i << 1;
      div_d   = d_i;
      cnt_d   = CntW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      rem_d   = mod_step(rem_q, shreg_q[WIDTH-1], div_q);
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q - 1'b1;
      done_d  = (cnt_q == CntW'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q   <= '0;
      shreg_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign rem_o  = rem_q;
  assign done_o = done_q;

endmodule

// File: rtl/prime_seq_checker.sv
// Sequential primality checker by trial division with odd divisors.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of prime_seq_checker_if
//                operand n accepted on in_valid && in_ready; result (isprime, smallest
//                non-trivial factor or 0) presented with out_valid until out_ready.
// One operand in flight; all handshake outputs are registered.
module prime_seq_checker
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  prime_seq_checker_if.slave bus
);
  localparam int unsigned ProdW = prod_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             isprime_q, isprime_d;
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             mod_start;
  logic [WIDTH-1:0] mod_rem;
  logic             mod_done;
  logic [ProdW-1:0] div_sq;

  assign div_sq = ProdW'(div_q) * ProdW'(div_q);

  prime_mod_unit #(
    .WIDTH (WIDTH)
  ) u_mod (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (mod_start),
    .n_i     (n_q),
    .d_i     (div_q),
    .rem_o   (mod_rem),
    .done_o  (mod_done)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    div_d     = div_q;
    isprime_d = isprime_q;
    factor_d  = factor_q;
    mod_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          n_d     = bus.in_data;
          state_d = StPre;
        end
      end
      StPre: begin
        state_d = StDone;
        if (n_q < WIDTH'(2)) begin
          isprime_d = 1'b0;
          factor_d  = '0;
        end else if ((n_q == WIDTH'(2)) || (n_q == WIDTH'(3))) begin
          isprime_d = 1'b1;
          factor_d  = '0;
        end else if (!n_q[0]) begin
          isprime_d = 1'b0;
          factor_d  = WIDTH'(2);
        end else begin
          div_d   = WIDTH'(DivStart);
          state_d = StTest;
        end
      end
      StTest: begin
        if (div_sq > ProdW'(n_q)) begin
          isprime_d = 1'b1;
          factor_d  = '0;
          state_d   = StDone;
        end else begin
          mod_start = 1'b1;
          state_d   = StMod;
        end
      end
      StMod: begin
        if (mod_done) begin
          if (mod_rem == '0) begin
            isprime_d = 1'b0;
            factor_d  = div_q;
            state_d   = StDone;
          end else begin
            div_d   = div_q + WIDTH'(DivStep);
            state_d = StTest;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered handshake outputs follow the state being entered
    out_valid_d = (state_d == StDone);
    in_ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      div_q       <= '0;
      isprime_q   <= 1'b0;
      factor_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      div_q       <= div_d;
      isprime_q   <= isprime_d;
      factor_q    <= factor_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.isprime   = isprime_q;
  assign bus.factor    = factor_q;

endmodule

// File: tb/tb_prime_seq_checker.sv
// Bench for prime_seq_checker: WIDTH=8 and WIDTH=4 instances sharing one stimulus driver.
module tb_prime_seq_checker;

  typedef struct {
    int n;
    bit prime;
    int factor;
    int lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sel4;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic       drv_ready;

  prime_seq_checker_if #(.WIDTH(8)) b8 ();
  prime_seq_checker_if #(.WIDTH(4)) b4 ();

  assign b8.in_valid  = drv_valid & ~sel4;
  assign b8.in_data   = drv_data;
  assign b8.out_ready = drv_ready;
  assign b4.in_valid  = drv_valid & sel4;
  assign b4.in_data   = drv_data[3:0];
  assign b4.out_ready = drv_ready;

  prime_seq_checker #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  prime_seq_checker #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  wire       mon_in_ready  = sel4 ? b4.in_ready : b8.in_ready;
  wire       mon_out_valid = sel4 ? b4.out_valid : b8.out_valid;
  wire       mon_isprime   = sel4 ? b4.isprime : b8.isprime;
  wire [7:0] mon_factor    = sel4 ? {4'b0000, b4.factor} : b8.factor;

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t sb_q[$];
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t model(input int n, input int w);
    vec_t r;
    int   k;
    r.n = n; r.prime = 1'b0; r.factor = 0; r.lat = 2;
    if (n < 2) return r;
    if (n == 2 || n == 3) begin r.prime = 1'b1; return r; end
    if (n % 2 == 0) begin r.factor = 2; return r; end
    k = 0;
    for (int d = 3; d * d <= n; d += 2) begin
      k++;
      if (n % d == 0) begin
        r.factor = d;
        r.lat    = 2 + k * (w + 1);
        return r;
      end
    end
    r.prime = 1'b1;
    r.lat   = 3 + k * (w + 1);
    return r;
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready_in_rst"}, mon_in_ready, 0);
    chk({tag, "_out_valid_in_rst"}, mon_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_in_ready"}, mon_in_ready, 1);
    chk({tag, "_out_valid"}, mon_out_valid, 0);
    chk({tag, "_isprime"}, mon_isprime, 0);
    chk({tag, "_factor"}, mon_factor, 0);
  endtask

  // Sends one operand; latency = edges from accept edge to the consuming edge.
  task automatic run_op(input vec_t e, input int hold, input bit chk_lat, input bit noisy);
    vec_t  g;
    int    lat, guard;
    string tag;
    tag = $sformatf("n%0d_w%0d", e.n, sel4 ? 4 : 8);
    drv_ready = (hold == 0);
    guard = 0;
    while (!mon_in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!mon_in_ready) begin chk({tag, "_in_ready_timeout"}, 0, 1); return; end
    drv_valid = 1'b1;
    drv_data  = 8'(e.n);
    @(posedge clk);
    sb_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (noisy) drv_data = 8'($urandom);
      else drv_valid = 1'b0;
    end while (!mon_out_valid && lat < 200);
    drv_valid = 1'b0;
    if (!mon_out_valid) begin
      chk({tag, "_out_valid_timeout"}, 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_bp_out_valid"}, mon_out_valid, 1);
      chk({tag, "_bp_isprime"}, mon_isprime, e.prime);
      chk({tag, "_bp_factor"}, mon_factor, e.factor);
      chk({tag, "_bp_in_ready"}, mon_in_ready, 0);
      @(negedge clk);
    end
    drv_ready = 1'b1;
    g = sb_q.pop_front();
    chk({tag, "_isprime"}, mon_isprime, g.prime);
    chk({tag, "_factor"}, mon_factor, g.factor);
    if (chk_lat) chk({tag, "_latency"}, lat, g.lat);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out_valid_drop"}, mon_out_valid, 0);
  endtask

  initial begin
    vec_t       e;
    int         seen;
    logic [15:0] pmask;
    pmask     = 16'h28AC;  // 2,3,5,7,11,13: the 4-bit combinational detector's truth table
    sel4      = 1'b0;
    drv_valid = 1'b0;
    drv_data  = '0;
    drv_ready = 1'b1;
    rst_n     = 1'b0;

    tbl[0] = '{n: 0,   prime: 1'b0, factor: 0,  lat: 2};
    tbl[1] = '{n: 1,   prime: 1'b0, factor: 0,  lat: 2};
    tbl[2] = '{n: 2,   prime: 1'b1, factor: 0,  lat: 2};
    tbl[3] = '{n: 3,   prime: 1'b1, factor: 0,  lat: 2};
    tbl[4] = '{n: 4,   prime: 1'b0, factor: 2,  lat: 2};
    tbl[5] = '{n: 5,   prime: 1'b1, factor: 0,  lat: 3};
    tbl[6] = '{n: 9,   prime: 1'b0, factor: 3,  lat: 11};
    tbl[7] = '{n: 25,  prime: 1'b0, factor: 5,  lat: 20};
    tbl[8] = '{n: 251, prime: 1'b1, factor: 0,  lat: 66};
    tbl[9] = '{n: 221, prime: 1'b0, factor: 13, lat: 56};

    do_reset("reset");

    for (int i = 0; i < 10; i++) run_op(tbl[i], 0, 1'b1, 1'b0);

    // Backpressure in DONE with in_data churning while busy
    run_op(tbl[6], 5, 1'b1, 1'b1);
    run_op(tbl[9], 5, 1'b0, 1'b1);

    // Reset while n=221 sits in MOD: result must vanish
    @(negedge clk);
    drv_valid = 1'b1;
    drv_data  = 8'd221;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid_in_rst", mon_out_valid, 0);
    chk("abort_in_ready_in_rst", mon_in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_ready_after", mon_in_ready, 1);
    seen = 0;
    repeat (80) begin
      if (mon_out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_out_valid", seen, 0);

    // Full WIDTH=8 sweep against the trial-division model
    for (int n = 0; n < 256; n++) run_op(model(n, 8), 0, 1'b1, 1'b0);

    // Exhaustive WIDTH=4, verdict taken from the combinational detector table
    sel4 = 1'b1;
    do_reset("reset_w4");
    for (int n = 0; n < 16; n++) begin
      e       = model(n, 4);
      e.prime = pmask[n];
      run_op(e, 0, 1'b1, 1'b0);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prime_seq_checker.md
# prime_seq_checker

Parametrised, sequential successor to the team's 4-bit combinational prime detector. It accepts an unsigned WIDTH-bit operand over a valid/ready handshake and decides primality by trial division with odd divisors. It returns the verdict and the smallest non-trivial factor over a second valid/ready handshake. It sits between an operand source (testbench or controller FSM) and a result consumer, one operand in flight at a time.

## Interface
- WIDTH, 8, operand width in bits (≥ 4).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand present on in_data.
- in_data  in  WIDTH  unsigned operand n.
- in_ready  out  1  block idle and able to accept.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- isprime  out  1  1 when n is prime.
- factor  out  WIDTH  smallest divisor d with 1 < d < n when n is composite; 0 when n is prime or n < 2.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture n and go to PRE.
  - PRE: resolve trivial cases, then go to DONE:
    - n<2: not prime, factor=0.
    - n=2 or 3: prime.
    - even n≥4: not prime, factor=2.
    - Otherwise: set d=3 and go to TEST.
  - TEST: compare d*d with n, computed at 2*WIDTH bits so no overflow.
    - If d*d > n: prime, factor=0, go to DONE.
    - Else: start the remainder unit on (n, d) and go to MOD.
  - MOD: wait WIDTH cycles for the remainder. On the final MOD cycle:
    - rem==0: not prime, factor=d, go to DONE.
    - Else: d ← d+2 and go to TEST.
  - DONE: out_valid=1 with isprime/factor stable. When out_ready=1, go to IDLE.
- Divisor d is held in WIDTH bits. The d*d>n exit guarantees d never exceeds about 2^(WIDTH/2)+1, so d never wraps.
- Operand handling:
  - in_data is sampled only on the accept cycle.
  - Changes on in_data or in_valid outside IDLE are ignored.
  - Back-to-back operands are never accepted while busy.
- out_valid and out_ready are both high in DONE: result consumed, return to IDLE. in_ready rises the next cycle, so there is no same-cycle accept.
- isprime and factor hold their last value outside DONE. They are only meaningful while out_valid=1.

## Timing
- Reset values: in_ready=0 during reset and 1 the first cycle after; out_valid=0, isprime=0, factor=0. FSM goes to IDLE, d=0, remainder unit cleared.
- Reset asserted mid-operation (PRE/TEST/MOD/DONE): abort immediately. The pending result is discarded and no out_valid pulse occurs.
- Latency, with accept edge = cycle 0:
  - Trivial cases: out_valid at cycle 2.
  - Prime found at the first TEST: out_valid at cycle 3.
  - Each divisor tried through MOD adds WIDTH+1 cycles.
- Worst case for WIDTH=8 is n=251, which tries d=3..15 (7 divisors): out_valid at cycle 3+7·9=66.
- Output is registered: out_valid is asserted from the first DONE cycle and stays high until the cycle out_ready is sampled high.

## Structure
- Shared package `prime_pkg`:
  - FSM state enum: IDLE, PRE, TEST, MOD, DONE.
  - Localparam for the product width, 2*WIDTH.
  - Constants DIV_START=3 and DIV_STEP=2.
- One sub-module, `prime_mod_unit`: restoring shift-subtract remainder, n mod d, one quotient bit per cycle.
  - Takes start, n, d.
  - Produces rem and done after exactly WIDTH cycles.
  - Holds rem until the next start.

## Test plan
- Reset with rst_n=0 for 2 cycles, then release: in_ready=1, out_valid=0, isprime=0, factor=0. Reset asserted during MOD of n=221: no out_valid, in_ready=1 the cycle after release.
- WIDTH=8, n=0,1,2,3,4: isprime=0,0,1,1,0 with factor=0,0,0,0,2, each out_valid at cycle 2 (out_ready held 1).
- n=5: isprime=1, factor=0 at cycle 3. n=9: isprime=0, factor=3 at cycle 11. n=25: isprime=0, factor=5 at cycle 20.
- n=251: isprime=1, factor=0 at cycle 66. n=221 (13·17): isprime=0, factor=13.
- Backpressure with out_ready=0 for 5 cycles in DONE: out_valid and the result stay stable and in_ready=0. Change in_data while busy: result unaffected.
- Exhaustive WIDTH=4 (n=0..15): isprime matches the 4-bit combinational detector for all 16 values. Sweep WIDTH=8 over n=0..255 against a reference model.
